// File: rtl/wb_cmd_pkg.sv
// Shared types and default constants for the Wishbone command master.
package wb_cmd_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam int unsigned DefTimeoutCycles = 255;
  localparam logic [31:0] DefTimeoutData   = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating bus-cycle counter; expired flags the last permitted cycle of a transfer.
module wb_timeout_ctr
  import wb_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [W-1:0] MaxCount  = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LastCount = (TIMEOUT_CYCLES > 0) ? W'(TIMEOUT_CYCLES - 1) : W'(0);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != MaxCount)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // count_q holds the number of completed bus cycles, so the current cycle is count_q + 1.
  assign expired = (TIMEOUT_CYCLES != 0) && (count_q >= LastCount);

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding command-to-Wishbone-classic initiator with timeout and response handshake.
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter logic [31:0] TIMEOUT_DATA   = DefTimeoutData
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [3:0]  wbs_sel_o,
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  input  logic        wbs_ack_i,
  input  logic [31:0] wbs_dat_i
);

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic        cmd_fire;
  logic        expired;

  // Gated by reset so no command can be offered while the block is held in reset.
  assign cmd_ready = (state_q == StIdle) && !wb_rst_i;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_valid = (state_q == StResp);

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (cmd_fire),
    .enable (state_q == StBus),
    .expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          state_d = StBus;
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
        end
      end
      StBus: begin
        if (wbs_ack_i || expired) begin
          state_d   = StResp;
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          sel_d     = '0;
          adr_d     = '0;
          dat_d     = '0;
          // Ack wins over a timeout landing on the same cycle.
          rsp_err_d = !wbs_ack_i;
          rsp_dat_d = we_q ? 32'h0 : (wbs_ack_i ? wbs_dat_i : TIMEOUT_DATA);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d   = StIdle;
          rsp_dat_d = '0;
          rsp_err_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = cyc_q;
  assign wbs_we_o  = we_q;
  assign wbs_sel_o = sel_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = dat_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed scenarios plus randomized transfers.
module tb_wb_cmd_master;

  localparam int unsigned TO = 8;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;
  localparam int NO_ACK = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [3:0]  wbs_sel_o;
  logic [31:0] wbs_adr_o, wbs_dat_o;
  logic        wbs_ack_i = 1'b0;
  logic [31:0] wbs_dat_i = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_DATA  (TO_DATA)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_sel  (cmd_sel),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbs_cyc_o(wbs_cyc_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_we_o (wbs_we_o),
    .wbs_sel_o(wbs_sel_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_ack_i(wbs_ack_i),
    .wbs_dat_i(wbs_dat_i)
  );

  // One full command: the responder acks on cyc cycle waits+1; the response is held for hold cycles.
  task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [31:0] rdata, input int waits,
                         input int hold, input string name);
    int          exp_cycles;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          n;
    int          guard;
    exp_err    = (waits + 1 > int'(TO));
    exp_cycles = exp_err ? int'(TO) : waits + 1;
    exp_dat    = we ? 32'h0 : (exp_err ? TO_DATA : rdata);

    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s idle_wait: cmd_ready=%b required 1", name, cmd_ready);
    end

    cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_we = ~we; cmd_sel = ~sel; cmd_adr = $urandom; cmd_dat = $urandom;

    n = 0;
    while (wbs_cyc_o === 1'b1 && n < 40) begin
      n++;
      checks++;
      if ({wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o, cmd_ready, rsp_valid} !==
          {1'b1, we, sel, adr, dat, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s bus_fields cyc#%0d: stb=%b we=%b sel=%h adr=%h dat=%h rdy=%b rv=%b required stb=1 we=%b sel=%h adr=%h dat=%h rdy=0 rv=0",
                 name, n, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o, cmd_ready,
                 rsp_valid, we, sel, adr, dat);
      end
      wbs_ack_i = (n == waits + 1);
      wbs_dat_i = wbs_ack_i ? rdata : $urandom;
      @(posedge clk); #1;
      wbs_ack_i = 1'b0;
    end

    checks++;
    if (n !== exp_cycles) begin
      failures++;
      $display("FAIL %s cyc_cycles: got %0d required %0d", name, n, exp_cycles);
    end
    checks++;
    if ({wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o} !== '0) begin
      failures++;
      $display("FAIL %s bus_idle: stb=%b we=%b sel=%h adr=%h dat=%h required all 0",
               name, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat, cmd_ready} !== {1'b1, exp_err, exp_dat, 1'b0}) begin
      failures++;
      $display("FAIL %s rsp: rv=%b err=%b dat=%h rdy=%b required rv=1 err=%b dat=%h rdy=0",
               name, rsp_valid, rsp_err, rsp_dat, cmd_ready, exp_err, exp_dat);
    end

    for (int i = 0; i < hold; i++) begin
      wbs_ack_i = 1'b1;
      wbs_dat_i = $urandom;
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_err, rsp_dat, cmd_ready, wbs_cyc_o} !==
          {1'b1, exp_err, exp_dat, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s rsp_hold%0d: rv=%b err=%b dat=%h rdy=%b cyc=%b required rv=1 err=%b dat=%h rdy=0 cyc=0",
                 name, i, rsp_valid, rsp_err, rsp_dat, cmd_ready, wbs_cyc_o, exp_err, exp_dat);
      end
    end
    wbs_ack_i = 1'b0;

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL %s rsp_done: rv=%b rdy=%b required rv=0 rdy=1", name, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o, rsp_dat, rsp_err,
         rsp_valid, cmd_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: cyc=%b stb=%b rv=%b rdy=%b dat=%h err=%b required all 0",
               wbs_cyc_o, wbs_stb_o, rsp_valid, cmd_ready, rsp_dat, rsp_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait_write();
    run_txn(1'b1, 4'hF, 32'h3000_0004, 32'h1234_5678, 32'h5555_AAAA, 0, 0, "zero_wait_write");
  endtask

  task automatic test_wait_read();
    run_txn(1'b0, 4'h3, 32'h4000_0010, 32'h0BAD_0BAD, 32'hCAFE_F00D, 3, 0, "wait3_read");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 4'hF, 32'h5000_0000, 32'h0, 32'h1111_2222, NO_ACK, 0, "timeout_read");
    run_txn(1'b1, 4'h1, 32'h5000_0008, 32'h7777_8888, 32'h1111_2222, NO_ACK, 0, "timeout_write");
  endtask

  task automatic test_collision();
    run_txn(1'b0, 4'hC, 32'h6000_0020, 32'h0, 32'h0123_4567, int'(TO) - 1, 0, "ack_vs_timeout");
  endtask

  task automatic test_backpressure();
    run_txn(1'b0, 4'hA, 32'h7000_0000, 32'h0, 32'h89AB_CDEF, 1, 5, "backpressure");
  endtask

  task automatic test_reset_mid_bus();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h8000_0000; cmd_dat = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wbs_cyc_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_bus_pre: cyc=%b required 1", wbs_cyc_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({wbs_cyc_o, wbs_stb_o, rsp_valid, cmd_ready, wbs_adr_o} !== '0) begin
      failures++;
      $display("FAIL mid_bus_reset: cyc=%b stb=%b rv=%b rdy=%b adr=%h required all 0",
               wbs_cyc_o, wbs_stb_o, rsp_valid, cmd_ready, wbs_adr_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL mid_bus_release: rdy=%b rv=%b required rdy=1 rv=0", cmd_ready, rsp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      wbs_ack_i = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, wbs_cyc_o, cmd_ready} !== 3'b001) begin
        failures++;
        $display("FAIL mid_bus_after%0d: rv=%b cyc=%b rdy=%b required rv=0 cyc=0 rdy=1",
                 i, rsp_valid, wbs_cyc_o, cmd_ready);
      end
    end
    wbs_ack_i = 1'b0;
    run_txn(1'b0, 4'h5, 32'h8000_0004, 32'h0, 32'hFEED_FACE, 2, 1, "post_reset_read");
  endtask

  task automatic test_back_to_back();
    int          accepts = 0;
    int          resps   = 0;
    logic [31:0] last_rd = '0;
    cmd_we = 1'b0; cmd_sel = 4'hF; cmd_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready === 1'b1) accepts++;
      if (rsp_valid === 1'b1) begin
        resps++;
        checks++;
        if ({rsp_err, rsp_dat} !== {1'b0, last_rd}) begin
          failures++;
          $display("FAIL b2b_rsp%0d: err=%b dat=%h required err=0 dat=%h",
                   i, rsp_err, rsp_dat, last_rd);
        end
      end
      wbs_ack_i = wbs_cyc_o;
      if (wbs_cyc_o === 1'b1) last_rd = $urandom;
      wbs_dat_i = last_rd;
      cmd_adr   = $urandom;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; wbs_ack_i = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (accepts !== 4 || resps !== 4) begin
      failures++;
      $display("FAIL b2b_rate: accepts=%0d resps=%0d in 12 cycles required 4 and 4",
               accepts, resps);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 12; k++) begin
      run_txn(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 10)), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_timeout();
    test_collision();
    test_backpressure();
    test_reset_mid_bus();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of bus cycles to wait for an ack (0 = wait forever).
REQ-002 SHALL have parameter TIMEOUT_DATA, default 32'hDEAD_BEEF, meaning the rsp_dat value returned on a timed-out read.
REQ-003 SHALL have port wb_clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port wb_rst_i, input, 1, the reset; asynchronous, active-high.
REQ-005 SHALL have port cmd_valid, input, 1, command request.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-007 SHALL have ports cmd_we, input, 1; cmd_sel, input, 4; cmd_adr, input, 32; cmd_dat, input, 32: command fields.
REQ-008 SHALL have port rsp_valid, output, 1, response available.
REQ-009 SHALL have port rsp_ready, input, 1, response consumed when high with rsp_valid.
REQ-010 SHALL have ports rsp_dat, output, 32, read data; rsp_err, output, 1, timeout flag.
REQ-011 SHALL have ports wbs_cyc_o, wbs_stb_o, wbs_we_o, output, 1 each; wbs_sel_o, output, 4; wbs_adr_o, output, 32; wbs_dat_o, output, 32: Wishbone classic initiator outputs.
REQ-012 SHALL have ports wbs_ack_i, input, 1; wbs_dat_i, input, 32: Wishbone responder returns.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUS, RESP.
REQ-014 SHALL drive cmd_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-015 SHALL, on cmd_valid&&cmd_ready at edge N, register all cmd fields and enter BUS, with wbs_cyc_o=wbs_stb_o=1 from cycle N+1.
REQ-016 SHALL, in BUS, hold cyc, stb, we, sel, adr and dat_o stable until ack is sampled or a timeout occurs.
REQ-017 SHALL drive wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o and wbs_dat_o all to 0 outside BUS; all outputs are registered.
REQ-018 SHALL, on wbs_ack_i sampled high in BUS, deassert cyc/stb on the next cycle and enter RESP with rsp_err=0.
REQ-019 SHALL, on ack, set rsp_dat to wbs_dat_i for a read and to 0 for a write.
REQ-020 SHALL count BUS cycles; if TIMEOUT_CYCLES>0 and cyc has been high for TIMEOUT_CYCLES cycles without ack, SHALL deassert cyc/stb and enter RESP with rsp_err=1 and rsp_dat=TIMEOUT_DATA (read) or 0 (write).
REQ-021 SHALL give ack priority over timeout when both occur on the same cycle.
REQ-022 SHALL ignore wbs_ack_i in IDLE and RESP.
REQ-023 SHALL hold rsp_dat and rsp_err stable in RESP until rsp_ready, then return to IDLE on the next edge.
REQ-024 SHALL size the timeout counter to clog2(TIMEOUT_CYCLES+1) bits, saturating, and clear it on BUS entry.
REQ-025 SHALL achieve a minimum turnaround of accept -> cyc high (1 cycle) -> ack -> rsp_valid (next cycle) -> IDLE, giving back-to-back commands every 3 cycles with zero-wait responders.

Reset
REQ-026 SHALL, on wb_rst_i high, immediately (asynchronously) enter IDLE and clear the counter.
REQ-027 SHALL, during reset, drive all Wishbone outputs, rsp_dat, rsp_err and rsp_valid to 0, and drive cmd_ready to 0.
REQ-028 SHALL, when reset is asserted mid-transaction, drop cyc/stb without waiting for ack and discard the response.
REQ-029 SHALL drive cmd_ready=1 on the first cycle after reset release.

Structure
REQ-030 SHALL place the state enum and the default TIMEOUT_CYCLES and TIMEOUT_DATA constants in package wb_cmd_pkg.
REQ-031 SHALL implement the timeout counter as sub-module wb_timeout_ctr (inputs clear, enable; output expired).

Verification
REQ-032 SHALL cover a zero-wait write: cmd adr=0x3000_0004, dat=0x1234_5678, sel=0xF -> cyc/stb high for exactly 1 cycle with those values; rsp_err=0, rsp_dat=0.
REQ-033 SHALL cover a read with 3 wait states: responder acks on the 4th cyc cycle with 0xCAFE_F00D -> rsp_dat=0xCAFE_F00D, rsp_err=0, fields stable for all 4 cycles.
REQ-034 SHALL cover a timeout: TIMEOUT_CYCLES=8 and no ack -> cyc high exactly 8 cycles; read rsp_dat=0xDEAD_BEEF with rsp_err=1.
REQ-035 SHALL cover ack-versus-timeout collision: ack on the 8th cycle with TIMEOUT_CYCLES=8 -> rsp_err=0 and rsp_dat=responder data.
REQ-036 SHALL cover backpressure: rsp_ready held low for 5 cycles -> rsp_valid and rsp_dat stable, cmd_ready=0, a stray ack is ignored.
REQ-037 SHALL cover reset mid-BUS: wb_rst_i pulsed in the 2nd wait cycle -> cyc/stb 0 in the same cycle, no rsp_valid, cmd_ready=1 after release.
